// File: rtl/lfsr_gen.sv
// Purpose : parametrised Fibonacci LFSR with reseed, on-demand word fill and period-wrap pulse.
// Latency : en step visible next cycle; a word is ready OUT_WIDTH+1 cycles after its req edge.
// Backpr. : none; req is ignored while busy, and rd_valid holds until the next req, seed_load or rst.
module lfsr_gen #(
   parameter int                 WIDTH     = 17,
   parameter logic [WIDTH-1:0]   TAPS      = 17'h12000,
   parameter logic [WIDTH-1:0]   SEED      = 17'h1BEEF,
   parameter int                 OUT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 seed_load,
   input  logic [WIDTH-1:0]     seed,
   input  logic                 req,
   output logic [OUT_WIDTH-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 busy,
   output logic [WIDTH-1:0]     state,
   output logic                 wrap
);

   // Counter only has to reach OUT_WIDTH-1; keep it at least one bit wide.
   localparam int CNT_W = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fsm_t;

   fsm_t             fsm;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] start;
   logic             fb;
   logic [WIDTH-1:0] s_nxt;
   logic [WIDTH-1:0] load_val;

   // Feedback bit and next state: XOR of tapped bits shifted in at the LSB.
   always_comb begin
      fb = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         fb = fb ^ (s[i] & TAPS[i]);
      end
      s_nxt = {s[WIDTH-2:0], fb};
   end

   // A zero seed would lock the register up, so it is replaced by SEED.
   assign load_val = (seed == '0) ? SEED : seed;

   // Single sequential block: rst > seed_load > FILL step > req accept > en step.
   always_ff @(posedge clk) begin
      if (rst) begin
         s        <= SEED;
         start    <= SEED;
         fsm      <= IDLE;
         cnt      <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         busy     <= 1'b0;
         wrap     <= 1'b0;
      end else if (seed_load) begin
         // Reload aborts any fill in progress; rd_data keeps the last word.
         s        <= load_val;
         start    <= load_val;
         fsm      <= IDLE;
         cnt      <= '0;
         rd_valid <= 1'b0;
         busy     <= 1'b0;
         wrap     <= 1'b0;
      end else if (fsm == FILL) begin
         s    <= s_nxt;
         wrap <= (s_nxt == start);
         cnt  <= cnt + CNT_W'(1);
         if (cnt == CNT_W'(OUT_WIDTH - 1)) begin
            rd_data  <= s_nxt[OUT_WIDTH-1:0];
            rd_valid <= 1'b1;
            fsm      <= IDLE;
            busy     <= 1'b0;
         end
      end else if (req) begin
         // Acceptance edge only arms the fill; the first step is on the next edge.
         fsm      <= FILL;
         busy     <= 1'b1;
         cnt      <= '0;
         rd_valid <= 1'b0;
         wrap     <= 1'b0;
      end else if (en) begin
         s    <= s_nxt;
         wrap <= (s_nxt == start);
      end else begin
         wrap <= 1'b0;
      end
   end

   assign state = s;

endmodule

// File: tb/tb_lfsr_gen.sv
module tb_lfsr_gen;

   logic        clk;
   logic        rst;

   // Default-parameter instance (17-bit)
   logic        en17, sl17, req17;
   logic [16:0] seed17;
   logic [15:0] rd17;
   logic        v17, b17, w17;
   logic [16:0] st17;

   // Small instance: WIDTH=4, TAPS=9, SEED=1, OUT_WIDTH=4
   logic        en4, sl4, req4;
   logic [3:0]  seed4;
   logic [3:0]  rd4;
   logic        v4, b4, w4;
   logic [3:0]  st4;

   int checks = 0;
   int errors = 0;

   // Hand-derived successor sequence of the 4-bit LFSR starting after state 1.
   logic [3:0] seq [15];

   lfsr_gen dut17 (
      .clk       (clk),
      .rst       (rst),
      .en        (en17),
      .seed_load (sl17),
      .seed      (seed17),
      .req       (req17),
      .rd_data   (rd17),
      .rd_valid  (v17),
      .busy      (b17),
      .state     (st17),
      .wrap      (w17)
   );

   lfsr_gen #(
      .WIDTH     (4),
      .TAPS      (4'h9),
      .SEED      (4'h1),
      .OUT_WIDTH (4)
   ) dut4 (
      .clk       (clk),
      .rst       (rst),
      .en        (en4),
      .seed_load (sl4),
      .seed      (seed4),
      .req       (req4),
      .rd_data   (rd4),
      .rd_valid  (v4),
      .busy      (b4),
      .state     (st4),
      .wrap      (w4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // en held for one full period starting from state seq[k]; wrap only on the last step.
   task automatic run_en(input int k);
      en4 = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("en_seq_state", {28'd0, st4}, {28'd0, seq[(k + 1 + i) % 15]});
         chk("en_seq_wrap", {31'd0, w4}, {31'd0, (i == 14)});
      end
      en4 = 1'b0;
   endtask

   // One-cycle req from state seq[k]; expects four steps and the word seq[k+4].
   task automatic word(input int k);
      req4 = 1'b1;
      tick();
      req4 = 1'b0;
      chk("acc_busy", {31'd0, b4}, 32'd1);
      chk("acc_state", {28'd0, st4}, {28'd0, seq[k]});
      chk("acc_valid", {31'd0, v4}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("fill_state", {28'd0, st4}, {28'd0, seq[(k + 1 + i) % 15]});
         if (i < 3) begin
            chk("fill_busy", {31'd0, b4}, 32'd1);
            chk("fill_valid", {31'd0, v4}, 32'd0);
         end else begin
            chk("done_busy", {31'd0, b4}, 32'd0);
            chk("done_valid", {31'd0, v4}, 32'd1);
            chk("done_data", {28'd0, rd4}, {28'd0, seq[(k + 4) % 15]});
         end
      end
   endtask

   initial begin
      seq = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB,
              4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};
      rst = 1'b1;
      en17 = 1'b0; sl17 = 1'b0; req17 = 1'b0; seed17 = '0;
      en4  = 1'b0; sl4  = 1'b0; req4  = 1'b0; seed4  = '0;
      tick();
      tick();
      rst = 1'b0;

      // Reset values
      chk("rst_state17", {15'd0, st17}, 32'h1BEEF);
      chk("rst_data17", {16'd0, rd17}, 32'd0);
      chk("rst_valid17", {31'd0, v17}, 32'd0);
      chk("rst_busy17", {31'd0, b17}, 32'd0);
      chk("rst_wrap17", {31'd0, w17}, 32'd0);
      chk("rst_state4", {28'd0, st4}, 32'h1);

      // Single en pulse on the 17-bit instance: taps 16,13 of 1BEEF XOR to 0
      en17 = 1'b1;
      tick();
      en17 = 1'b0;
      chk("en_state17", {15'd0, st17}, 32'h17DDE);
      chk("en_wrap17", {31'd0, w17}, 32'd0);
      tick();
      chk("hold_state17", {15'd0, st17}, 32'h17DDE);

      // Zero seed substitutes SEED
      sl17 = 1'b1; seed17 = '0;
      tick();
      sl17 = 1'b0;
      chk("zseed_state17", {15'd0, st17}, 32'h1BEEF);

      // Two full periods of the 4-bit LFSR: wrap once per 15 steps
      run_en(14);
      run_en(14);
      tick();
      chk("idle_wrap4", {31'd0, w4}, 32'd0);
      chk("idle_state4", {28'd0, st4}, 32'h1);

      // First word from state 1 -> E; rd_valid persists while idle
      word(14);
      tick();
      chk("persist_valid", {31'd0, v4}, 32'd1);
      chk("persist_state", {28'd0, st4}, 32'hE);

      // Second word from E -> B
      word(3);

      // req and en together: req wins, en ignored in FILL, exactly 4 steps
      en4 = 1'b1;
      word(7);
      en4 = 1'b0;
      tick();
      chk("no_extra_step", {28'd0, st4}, 32'h2);
      chk("no_extra_valid", {31'd0, v4}, 32'd1);

      // Held req: back-to-back words, wrap seen mid-fill, rd_valid high one cycle
      req4 = 1'b1;
      tick();
      chk("held_acc_busy", {31'd0, b4}, 32'd1);
      chk("held_acc_state", {28'd0, st4}, 32'h2);
      tick();
      chk("held_s1", {28'd0, st4}, 32'h4);
      tick();
      chk("held_s2", {28'd0, st4}, 32'h8);
      tick();
      chk("held_s3", {28'd0, st4}, 32'h1);
      chk("held_wrap", {31'd0, w4}, 32'd1);
      tick();
      chk("held_s4", {28'd0, st4}, 32'h3);
      chk("held_wrap_off", {31'd0, w4}, 32'd0);
      chk("held_valid", {31'd0, v4}, 32'd1);
      chk("held_data", {28'd0, rd4}, 32'h3);
      chk("held_busy_off", {31'd0, b4}, 32'd0);
      tick();
      req4 = 1'b0;
      chk("retrig_valid", {31'd0, v4}, 32'd0);
      chk("retrig_busy", {31'd0, b4}, 32'd1);
      chk("retrig_state", {28'd0, st4}, 32'h3);
      for (int i = 0; i < 4; i++) tick();
      chk("retrig_data", {28'd0, rd4}, 32'hD);
      chk("retrig_done", {31'd0, v4}, 32'd1);

      // seed_load of 5 mid-FILL aborts the fill and keeps rd_data
      req4 = 1'b1;
      tick();
      req4 = 1'b0;
      tick();
      chk("abort_pre_state", {28'd0, st4}, 32'hA);
      sl4 = 1'b1; seed4 = 4'h5;
      tick();
      sl4 = 1'b0;
      chk("abort_busy", {31'd0, b4}, 32'd0);
      chk("abort_valid", {31'd0, v4}, 32'd0);
      chk("abort_state", {28'd0, st4}, 32'h5);
      chk("abort_data", {28'd0, rd4}, 32'hD);
      chk("abort_wrap", {31'd0, w4}, 32'd0);
      tick();
      chk("abort_idle_state", {28'd0, st4}, 32'h5);
      chk("abort_idle_busy", {31'd0, b4}, 32'd0);
      // start now 5: wrap must fire on the return to 5
      run_en(6);

      // Zero seed on the small instance -> SEED; start follows
      sl4 = 1'b1; seed4 = 4'h0;
      tick();
      sl4 = 1'b0;
      chk("zseed_state4", {28'd0, st4}, 32'h1);
      chk("zseed_wrap4", {31'd0, w4}, 32'd0);
      run_en(14);

      // seed_load on the final FILL edge wins: no word produced
      req4 = 1'b1;
      tick();
      req4 = 1'b0;
      tick();
      tick();
      tick();
      chk("late_pre_state", {28'd0, st4}, 32'hF);
      sl4 = 1'b1; seed4 = 4'hA;
      tick();
      sl4 = 1'b0;
      chk("late_valid", {31'd0, v4}, 32'd0);
      chk("late_busy", {31'd0, b4}, 32'd0);
      chk("late_state", {28'd0, st4}, 32'hA);
      chk("late_data", {28'd0, rd4}, 32'hD);
      tick();
      chk("late_idle_state", {28'd0, st4}, 32'hA);

      // rst mid-FILL at cnt=2 discards the partial word
      req4 = 1'b1;
      tick();
      req4 = 1'b0;
      tick();
      tick();
      chk("midrst_pre_state", {28'd0, st4}, 32'hB);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_state", {28'd0, st4}, 32'h1);
      chk("midrst_busy", {31'd0, b4}, 32'd0);
      chk("midrst_valid", {31'd0, v4}, 32'd0);
      chk("midrst_data", {28'd0, rd4}, 32'd0);
      chk("midrst_wrap", {31'd0, w4}, 32'd0);
      chk("midrst_state17", {15'd0, st17}, 32'h1BEEF);
      // Same first word as after power-up
      word(14);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
